// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch controller.
//   fetch_state_e : controller FSM states
//   ADDR_W        : address/data width
//   INST_BYTES    : bytes per instruction (sequential PC step)
//   RESET_VEC     : PC value assumed after reset (must match the PC register)
//   align_addr()  : clears the byte-offset bits of an address
package fetch_ctrl_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INST_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDeliver,
        StHalted
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles every non-clock/reset signal of the fetch controller.
//   PC register : pc_q (in), pc_en / pc_next (out)
//   imem        : imem_req_valid/addr (out), imem_req_ready, imem_rsp_valid/data (in)
//   decode      : inst_valid/data/pc (out), inst_ready (in)
//   control     : redir_valid/addr, halt_req (in), halted, misalign_trap/addr (out)
// Modport master is the fetch controller; slave is its environment.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic              pc_en;
    logic [ADDR_W-1:0] pc_next;

    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [ADDR_W-1:0] imem_rsp_data;

    logic              inst_valid;
    logic [ADDR_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    logic              redir_valid;
    logic [ADDR_W-1:0] redir_addr;
    logic              halt_req;
    logic              halted;
    logic              misalign_trap;
    logic [ADDR_W-1:0] misalign_addr;

    modport master (
        input  pc_q,
        output pc_en, pc_next,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready,
        input  redir_valid, redir_addr, halt_req,
        output halted, misalign_trap, misalign_addr
    );

    modport slave (
        output pc_q,
        input  pc_en, pc_next,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready,
        output redir_valid, redir_addr, halt_req,
        input  halted, misalign_trap, misalign_addr
    );

endinterface

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: one-entry instruction buffer between imem and decode.
//   clk, rst      : clock, synchronous active-low reset (clears valid and contents)
//   load_i        : capture data_i/pc_i and set valid
//   clear_i       : drop the entry (wins over load_i)
//   data_i, pc_i  : instruction word and its address
//   valid_o       : entry present
//   data_o, pc_o  : held instruction word and address
module fetch_inst_buf
    import fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] data_q;
    logic [ADDR_W-1:0] inst_pc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            inst_pc_q <= '0;
        end else if (clear_i) begin
            // Contents are kept so inst_data/inst_pc do not glitch after a drop.
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            data_q    <= data_i;
            inst_pc_q <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = inst_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the PC register, issues one imem request per PC value and
// hands each fetched instruction to decode. One transaction outstanding at a time.
//   clk : clock, all state updates on posedge
//   rst : synchronous active-low reset
//   bus : fetch_ctrl_if.master (PC register, imem, decode, redirect/halt control)
// Optional feature macro FETCH_CTRL_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target halts fetch and pulses misalign_trap; otherwise the target is silently aligned
// and misalign_trap/misalign_addr are tied to 0.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    fetch_state_e state_q;
    logic         kill_q;          // response of the outstanding request must be discarded
    logic         halt_pending_q;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_data;
    logic [ADDR_W-1:0] buf_pc;

    logic              redir;      // redirect honoured (ignored in IDLE)
    logic              redir_bad;  // misaligned redirect that traps
    logic              halt_now;
    logic              req_valid;
    logic              inst_valid;
    logic              pc_en;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic              req_fire;
    logic              deliver_fire;
    logic              buf_load;
    logic              buf_clear;

    assign redir     = bus.redir_valid && (state_q != StIdle);
    assign redir_bad = TrapEn && redir && (bus.redir_addr[1:0] != 2'b00);
    assign halt_now  = halt_pending_q || bus.halt_req;
    assign pc_inc    = bus.pc_q + ADDR_W'(INST_BYTES);

    always_comb begin
        req_valid  = 1'b0;
        inst_valid = 1'b0;
        pc_en      = 1'b0;
        pc_next    = pc_inc;
        unique case (state_q)
            // A killed response may still be in flight after a trap resume.
            StReq:     req_valid  = !bus.redir_valid && !kill_q;
            StDeliver: inst_valid = buf_valid && !bus.redir_valid;
            default: ;
        endcase
        if (redir) begin
            if (!redir_bad) begin
                pc_en   = 1'b1;
                pc_next = align_addr(bus.redir_addr);
            end
        end else if (inst_valid && bus.inst_ready) begin
            pc_en = 1'b1;
        end
    end

    assign req_fire     = req_valid && bus.imem_req_ready;
    assign deliver_fire = inst_valid && bus.inst_ready;
    assign buf_load     = (state_q == StWait) && bus.imem_rsp_valid && !kill_q && !redir;
    assign buf_clear    = (state_q == StDeliver) && (redir || deliver_fire);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            kill_q         <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            halt_pending_q <= halt_pending_q || bus.halt_req;
            if (kill_q && bus.imem_rsp_valid) begin
                kill_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: state_q <= halt_now ? StHalted : StReq;
                StReq: begin
                    if (redir_bad) begin
                        state_q <= StHalted;
                    end else if (!redir && req_fire) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (redir) begin
                        // A response arriving with the redirect closes the transaction.
                        if (bus.imem_rsp_valid) begin
                            kill_q  <= 1'b0;
                            state_q <= redir_bad ? StHalted : StReq;
                        end else begin
                            kill_q <= 1'b1;
                            if (redir_bad) begin
                                state_q <= StHalted;
                            end
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (kill_q) begin
                            state_q <= halt_now ? StHalted : StReq;
                        end else begin
                            state_q <= StDeliver;
                        end
                    end
                end
                StDeliver: begin
                    if (redir_bad) begin
                        state_q <= StHalted;
                    end else if (redir) begin
                        state_q <= StReq;
                    end else if (deliver_fire) begin
                        state_q <= halt_now ? StHalted : StReq;
                    end
                end
                StHalted: begin
                    if (redir && !redir_bad) begin
                        state_q        <= StReq;
                        halt_pending_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fetch_inst_buf u_inst_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .data_i  (bus.imem_rsp_data),
        .pc_i    (bus.pc_q),
        .valid_o (buf_valid),
        .data_o  (buf_data),
        .pc_o    (buf_pc)
    );

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic              misalign_trap_q;
    logic [ADDR_W-1:0] misalign_addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_trap_q <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_trap_q <= redir_bad;
            if (redir_bad) begin
                misalign_addr_q <= bus.redir_addr;
            end
        end
    end

    assign bus.misalign_trap = misalign_trap_q;
    assign bus.misalign_addr = misalign_addr_q;
`else
    assign bus.misalign_trap = 1'b0;
    assign bus.misalign_addr = '0;
`endif

    assign bus.pc_en          = pc_en;
    assign bus.pc_next        = pc_next;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = bus.pc_q;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_data      = buf_data;
    assign bus.inst_pc        = buf_pc;
    assign bus.halted         = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl, checked every
// cycle against a transaction-level model (outstanding / holding / stopped flags and an
// expected PC). Provides the PC register and a variable-latency instruction memory.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // PC register
    logic [31:0] pc_init = 32'h0;
    always @(posedge clk) begin
        if (!rst) bus.pc_q <= pc_init;
        else if (bus.pc_en) bus.pc_q <= bus.pc_next;
    end

    // Instruction memory: one request at a time, response lat cycles after accept.
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int unsigned mem_cnt  = 0;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    assign bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
    assign bus.imem_rsp_data  = mem_word(mem_addr);
    always @(posedge clk) begin
        if (!rst) begin
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy <= 1'b0;
            else mem_cnt <= mem_cnt - 1;
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_busy <= 1'b1;
            mem_addr <= bus.imem_req_addr;
            mem_cnt  <= $urandom_range(lat_max, lat_min) - 1;
        end
    end

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    bit          m_known = 1'b0;
    bit          m_booted, m_stop, m_out, m_kill, m_hold, m_want;
    logic [31:0] m_pc, m_buf_pc;

    task automatic model_check();
        bit          redir;
        bit          exp_en;
        bit          exp_req;
        logic [31:0] exp_next;
        if (!m_known) return;
        redir    = bus.redir_valid && m_booted;
        exp_en   = redir || (m_hold && bus.inst_ready);
        exp_next = redir ? {bus.redir_addr[31:2], 2'b00} : m_pc + 32'd4;
        exp_req  = m_booted && !m_stop && !m_out && !m_hold && !bus.redir_valid;
        check("pc_q", bus.pc_q, m_pc);
        check("pc_en", 32'(bus.pc_en), 32'(exp_en));
        if (exp_en) check("pc_next", bus.pc_next, exp_next);
        check("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) check("imem_req_addr", bus.imem_req_addr, m_pc);
        check("inst_valid", 32'(bus.inst_valid), 32'(m_hold && !bus.redir_valid));
        if (m_hold) begin
            check("inst_pc", bus.inst_pc, m_buf_pc);
            check("inst_data", bus.inst_data, mem_word(m_buf_pc));
        end
        check("halted", 32'(bus.halted), 32'(m_stop));
        check("misalign_trap", 32'(bus.misalign_trap), 32'h0);
        check("rsp_outside_wait", 32'(bus.imem_rsp_valid && !m_out), 32'h0);
    endtask

    task automatic model_step();
        bit          want;
        bit          arrive;
        logic [31:0] tgt;
        if (!rst) begin
            m_known = 1'b1; m_booted = 1'b0; m_stop = 1'b0; m_out = 1'b0;
            m_kill = 1'b0; m_hold = 1'b0; m_want = 1'b0; m_pc = pc_init;
            return;
        end
        if (!m_known) return;
        want   = m_want || bus.halt_req;
        tgt    = {bus.redir_addr[31:2], 2'b00};
        arrive = 1'b0;
        if (!m_booted) begin
            m_booted = 1'b1;
            arrive   = 1'b1;
        end else if (m_stop) begin
            if (bus.redir_valid) begin
                m_stop = 1'b0; want = 1'b0; m_pc = tgt;
            end
        end else if (m_out) begin
            if (bus.redir_valid) begin
                m_pc = tgt;
                if (bus.imem_rsp_valid) begin m_out = 1'b0; m_kill = 1'b0; end
                else m_kill = 1'b1;
            end else if (bus.imem_rsp_valid) begin
                m_out = 1'b0;
                if (m_kill) begin m_kill = 1'b0; arrive = 1'b1; end
                else begin m_hold = 1'b1; m_buf_pc = m_pc; end
            end
        end else if (m_hold) begin
            if (bus.redir_valid) begin
                m_hold = 1'b0; m_pc = tgt;
            end else if (bus.inst_ready) begin
                m_hold = 1'b0; m_pc = m_pc + 32'd4; arrive = 1'b1;
            end
        end else begin
            if (bus.redir_valid) m_pc = tgt;
            else if (bus.imem_req_ready) m_out = 1'b1;
        end
        if (arrive && want) m_stop = 1'b1;
        m_want = want;
    endtask

    task automatic step();
        #1;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redir_valid    = 1'b0;
        bus.redir_addr     = 32'h0;
        bus.halt_req       = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        pc_init = start_pc;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        quiet_inputs();
        do_reset(32'h0);

        // c0: IDLE
        #1;
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst_pc_en", 32'(bus.pc_en), 32'h0);
        check("rst_trap", 32'(bus.misalign_trap), 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        step();
        // c1: REQ 0x0
        #1; check("seq_req_0", bus.imem_req_addr, 32'h0);
        check("seq_req_0_valid", 32'(bus.imem_req_valid), 32'h1);
        step(); step();
        // c3: DELIVER 0x0
        #1; check("seq_inst_pc_0", bus.inst_pc, 32'h0);
        check("seq_pc_next_4", bus.pc_next, 32'h4);
        step();
        // c4: REQ 0x4
        #1; check("seq_req_4", bus.imem_req_addr, 32'h4);
        step(); step(); step();
        // c7: REQ 0x8
        #1; check("seq_req_8", bus.imem_req_addr, 32'h8);
        step(); step();

        // c9: DELIVER 0x8, decode stalls for 5 cycles
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", 32'(bus.inst_valid), 32'h1);
            check("stall_pc", bus.inst_pc, 32'h8);
            check("stall_data", bus.inst_data, mem_word(32'h8));
            check("stall_pc_en", 32'(bus.pc_en), 32'h0);
            step();
        end
        bus.inst_ready = 1'b1;
        lat_min = 2; lat_max = 2;
        #1; check("release_pc_en", 32'(bus.pc_en), 32'h1);
        check("release_pc_next", bus.pc_next, 32'hC);
        step();
        // REQ 0xC accepted with latency 2
        step();
        // WAIT, no response yet: redirect
        bus.redir_valid = 1'b1; bus.redir_addr = 32'h100;
        #1; check("wait_redir_pc_en", 32'(bus.pc_en), 32'h1);
        check("wait_redir_next", bus.pc_next, 32'h100);
        step();
        bus.redir_valid = 1'b0;
        #1; check("killed_rsp_valid", 32'(bus.imem_rsp_valid), 32'h1);
        check("killed_no_inst", 32'(bus.inst_valid), 32'h0);
        step();
        lat_min = 1; lat_max = 1;
        #1; check("redir_req_addr", bus.imem_req_addr, 32'h100);
        check("redir_req_valid", 32'(bus.imem_req_valid), 32'h1);
        step();

        // WAIT 0x100 with halt request
        bus.halt_req = 1'b1;
        step();
        bus.halt_req = 1'b0;
        #1; check("halt_deliver_valid", 32'(bus.inst_valid), 32'h1);
        check("halt_deliver_pc", bus.inst_pc, 32'h100);
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halted", 32'(bus.halted), 32'h1);
            check("halted_no_req", 32'(bus.imem_req_valid), 32'h0);
            step();
        end
        bus.redir_valid = 1'b1; bus.redir_addr = 32'h40;
        #1; check("resume_next", bus.pc_next, 32'h40);
        step();
        bus.redir_valid = 1'b0;
        #1; check("resume_halted", 32'(bus.halted), 32'h0);
        check("resume_req_addr", bus.imem_req_addr, 32'h40);
        step(); step(); step();

        // REQ 0x44: redirect to a misaligned target
        bus.redir_valid = 1'b1; bus.redir_addr = 32'h102;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        m_known = 1'b0;
        #1; check("trap_pc_en", 32'(bus.pc_en), 32'h0);
        step();
        bus.redir_valid = 1'b0;
        #1; check("trap_pulse", 32'(bus.misalign_trap), 32'h1);
        check("trap_addr", bus.misalign_addr, 32'h102);
        check("trap_halted", 32'(bus.halted), 32'h1);
        step();
        #1; check("trap_pulse_end", 32'(bus.misalign_trap), 32'h0);
        step();
`else
        #1; check("unaligned_next", bus.pc_next, 32'h100);
        step();
        bus.redir_valid = 1'b0;
        #1; check("unaligned_req", bus.imem_req_addr, 32'h100);
        step();
`endif

        // PC wrap-around
        do_reset(32'hFFFF_FFFC);
        step();
        #1; check("wrap_req", bus.imem_req_addr, 32'hFFFF_FFFC);
        step(); step();
        #1; check("wrap_pc_next", bus.pc_next, 32'h0);
        step();
        #1; check("wrap_req_0", bus.imem_req_addr, 32'h0);
        step();

        // Randomized traffic
        do_reset(32'h0);
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.inst_ready     = ($urandom_range(2, 0) != 0);
            bus.redir_valid    = ($urandom_range(15, 0) == 0);
            bus.redir_addr     = $urandom;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            bus.redir_addr[1:0] = 2'b00;
`endif
            bus.halt_req       = ($urandom_range(39, 0) == 0);
            rst                = ($urandom_range(799, 0) != 0);
            step();
        end
        rst = 1'b1;
        quiet_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
